// File: rtl/ysyx_220066_ifu_if.sv
// Bus bundle of the instruction fetch unit: imem request/response, the instr hand-off to ID,
// and the redirect/halt controls from later stages.
interface ysyx_220066_ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_err;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        halt;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, instr_err,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  instr_ready, redirect, redirect_pc, halt
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, instr_err,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output instr_ready, redirect, redirect_pc, halt
  );
endinterface

// File: rtl/ysyx_220066_ifu.sv
// Instruction fetch unit: credit-limited imem requests, response FIFO toward ID, redirect squash.
// Define YSYX_220066_IFU_PERF_EN to add the perf_fetched/perf_stall counters.
module ysyx_220066_ifu #(
  parameter logic [63:0] RESET_PC   = 64'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic               clk,
  input logic               rst_n,
  ysyx_220066_ifu_if.master bus
`ifdef YSYX_220066_IFU_PERF_EN
  ,
  output logic [63:0]       perf_fetched,
  output logic [63:0]       perf_stall
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(FIFO_DEPTH - 1);

  typedef enum logic {FETCH, FAULT} state_t;
  state_t state, state_next;

  logic [63:0]   fetch_pc, rsp_pc;
  logic [CW-1:0] pend, drop, count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   mem_instr [FIFO_DEPTH];
  logic [63:0]   mem_pc    [FIFO_DEPTH];
  logic          mem_err   [FIFO_DEPTH];

  logic        req_valid, req_fire, instr_valid, pop;
  logic        rsp_push, mis_push, push;
  logic [31:0] push_instr;
  logic [63:0] push_pc;
  logic        push_err;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    state_next = state;
    push_instr = '0;
    push_pc    = '0;
    push_err   = 1'b0;
    // Requests are held back while in-flight plus buffered entries would exceed the FIFO.
    req_valid   = rst_n && (state == FETCH) && !bus.halt && !bus.redirect &&
                  (fetch_pc[1:0] == 2'b00) && (({1'b0, pend} + {1'b0, count}) < DEPTH_W);
    req_fire    = req_valid && bus.imem_req_ready;
    instr_valid = (count != '0) && !bus.redirect;
    pop         = instr_valid && bus.instr_ready;
    rsp_push    = bus.imem_rsp_valid && (drop == '0) && (state == FETCH) && !bus.redirect;
    mis_push    = (state == FETCH) && (fetch_pc[1:0] != 2'b00) && (pend == '0) &&
                  (count != DEPTH_C) && !bus.redirect;
    push        = rsp_push || mis_push;
    if (rsp_push) begin
      push_instr = bus.imem_rsp_err ? 32'd0 : bus.imem_rsp_data;
      push_pc    = rsp_pc;
      push_err   = bus.imem_rsp_err;
      if (bus.imem_rsp_err) state_next = FAULT;
    end else if (mis_push) begin
      push_pc    = fetch_pc;
      push_err   = 1'b1;
      state_next = FAULT;
    end
    if (bus.redirect) state_next = FETCH;
  end

  // Stale responses already requested before a redirect are counted into drop and discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      pend     <= '0;
      drop     <= '0;
    end else begin
      state <= state_next;
      pend  <= pend + CW'(req_fire) - CW'(bus.imem_rsp_valid);
      if (bus.redirect) begin
        fetch_pc <= bus.redirect_pc;
        rsp_pc   <= bus.redirect_pc;
        drop     <= pend - CW'(bus.imem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 64'd4;
        if (rsp_push) rsp_pc <= rsp_pc + 64'd4;
        if (bus.imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
        mem_err[i]   <= 1'b0;
      end
    end else if (bus.redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= push_instr;
        mem_pc[wr_ptr]    <= push_pc;
        mem_err[wr_ptr]   <= push_err;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.instr_valid    = instr_valid;
  assign bus.instr          = mem_instr[rd_ptr];
  assign bus.instr_pc       = mem_pc[rd_ptr];
  assign bus.instr_err      = mem_err[rd_ptr];

`ifdef YSYX_220066_IFU_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      perf_fetched <= perf_fetched + 64'(pop);
      perf_stall   <= perf_stall + 64'(!instr_valid && !bus.halt);
    end
  end
`endif
endmodule

// File: tb/tb_ysyx_220066_ifu.sv
// Randomized scoreboard bench for ysyx_220066_ifu: a bench-side memory answers fetches and every
// redirect/reset pushes the instruction stream ID is expected to see from that target onward.
`timescale 1ns/1ps
module tb_ysyx_220066_ifu;
  localparam logic [63:0] RESET_PC   = 64'h8000_0000;
  localparam int          FIFO_DEPTH = 2;
  localparam int          NUM_CYCLES = 4000;
  localparam int          MID_RESET  = 2000;
  localparam int          SEG_LEN    = 64;
  localparam int          MAX_AGE    = 40;

  typedef struct packed { logic [31:0] instr; logic [63:0] pc; logic err; } entry_t;
  typedef struct packed { logic [63:0] addr; int due; } mem_req_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ysyx_220066_ifu_if bus ();
`ifdef YSYX_220066_IFU_PERF_EN
  logic [63:0] perf_fetched, perf_stall;
`endif

  ysyx_220066_ifu #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef YSYX_220066_IFU_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall(perf_stall)
`endif
  );

  // Stimulus-side state
  int       cyc, epoch, seg_base, age, phase_end, reset_until;
  bit       done;
  entry_t   exp_q[$];
  mem_req_t pending_q[$];

  // Monitor-side state
  int          tests, fails, mon_epoch, rd_idx, fault_epoch, rel_cnt;
  int          first_rsp, first_valid, hs_since_reset, stall_since_reset, total_hs;
  logic        prev_stall;
  logic [63:0] prev_addr;
  bit          final_done;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
  endfunction

  function automatic logic mem_fault(input logic [63:0] a);
    return ((a >> 2) % 64'd29) == 64'd7;
  endfunction

  // Expected stream from a target: sequential words up to and including the first fault.
  task automatic start_segment(input logic [63:0] target);
    logic [63:0] pc;
    epoch++;
    seg_base = exp_q.size();
    if (target[1:0] != 2'b00) begin
      exp_q.push_back(entry_t'{instr: 32'd0, pc: target, err: 1'b1});
    end else begin
      pc = target;
      for (int k = 0; k < SEG_LEN; k++) begin
        if (mem_fault(pc)) begin
          exp_q.push_back(entry_t'{instr: 32'd0, pc: pc, err: 1'b1});
          break;
        end
        exp_q.push_back(entry_t'{instr: mem_word(pc), pc: pc, err: 1'b0});
        pc = pc + 64'd4;
      end
    end
  endtask

  task automatic applyStimulus();
    mem_req_t    head;
    logic [63:0] target;
    age++;
    if (cyc == MID_RESET) begin
      rst_n = 1'b0;
      pending_q.delete();
      reset_until = cyc + 3;
      phase_end = cyc + 33;
      age = 0;
      start_segment(RESET_PC);
    end else if (!rst_n && cyc >= reset_until) begin
      rst_n = 1'b1;
    end

    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = $urandom;
    bus.imem_rsp_err   = 1'b0;
    if (rst_n && pending_q.size() > 0 && pending_q[0].due <= cyc) begin
      head = pending_q.pop_front();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(head.addr);
      bus.imem_rsp_err   = mem_fault(head.addr);
    end

    if (!rst_n || cyc < phase_end) begin
      bus.imem_req_ready = 1'b1;
      bus.instr_ready    = 1'b1;
      bus.halt           = 1'b0;
      bus.redirect       = 1'b0;
      bus.redirect_pc    = '0;
    end else begin
      bus.imem_req_ready = ($urandom % 4) != 0;
      bus.instr_ready    = ($urandom % 10) < 7;
      if ($urandom % 25 == 0) bus.halt = !bus.halt;
      if (!bus.redirect && (age >= MAX_AGE || $urandom % 32 == 0)) begin
        case ($urandom % 8)
          0: target = RESET_PC + 64'($urandom_range(0, 1023)) * 64'd4 + 64'($urandom_range(1, 3));
          1: target = 64'hFFFF_FFFF_FFFF_FFF0 - 64'($urandom_range(0, 4)) * 64'd4;
          2: target = RESET_PC + 64'h100;
          3: target = RESET_PC + 64'h102;
          default: target = RESET_PC + 64'($urandom_range(0, 1023)) * 64'd4;
        endcase
        bus.redirect    = 1'b1;
        bus.redirect_pc = target;
        start_segment(target);
        age = 0;
      end else begin
        bus.redirect    = 1'b0;
        bus.redirect_pc = {$urandom, $urandom};
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Stimulus and bench-side instruction memory (in-order responses, 1..3 cycle latency).
  initial begin
    rst_n = 1'b1;
    done = 1'b0;
    epoch = 0;
    age = 0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.imem_rsp_err   = 1'b0;
    bus.instr_ready    = 1'b0;
    bus.redirect       = 1'b0;
    bus.redirect_pc    = '0;
    bus.halt           = 1'b0;
    start_segment(RESET_PC);
    #2 rst_n = 1'b0;
    reset_until = 3;
    phase_end = 33;
    for (cyc = 0; cyc < NUM_CYCLES; cyc++) begin
      @(negedge clk);
      if (rst_n && bus.imem_req_valid && bus.imem_req_ready)
        pending_q.push_back(mem_req_t'{addr: bus.imem_req_addr,
                                       due: (cyc < phase_end) ? cyc + 1 : cyc + int'($urandom_range(1, 3))});
      @(posedge clk);
      #1;
      applyStimulus();
    end
    done = 1'b1;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Monitor: pops the expected stream on every ID handshake and checks request-side rules.
  initial begin
    entry_t exp;
    tests = 0;
    fails = 0;
    mon_epoch = -1;
    fault_epoch = -2;
    rd_idx = 0;
    total_hs = 0;
    final_done = 1'b0;
    prev_stall = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (epoch != mon_epoch) begin
        mon_epoch = epoch;
        rd_idx = seg_base;
      end
      if (!rst_n) begin
        rel_cnt = 0;
        first_rsp = -1;
        first_valid = -1;
        hs_since_reset = 0;
        stall_since_reset = 0;
        prev_stall = 1'b0;
        checkOutput("reset_req_valid", 64'(bus.imem_req_valid), 64'd0);
        checkOutput("reset_req_addr", bus.imem_req_addr, RESET_PC);
        checkOutput("reset_instr_valid", 64'(bus.instr_valid), 64'd0);
        checkOutput("reset_instr", 64'(bus.instr), 64'd0);
        checkOutput("reset_instr_pc", bus.instr_pc, 64'd0);
        checkOutput("reset_instr_err", 64'(bus.instr_err), 64'd0);
      end else begin
        rel_cnt++;
        if (rel_cnt == 1) begin
          checkOutput("first_req_valid", 64'(bus.imem_req_valid), 64'd1);
          checkOutput("first_req_addr", bus.imem_req_addr, RESET_PC);
        end
        if (rel_cnt == 2) checkOutput("second_req_addr", bus.imem_req_addr, RESET_PC + 64'd4);
        if (bus.imem_rsp_valid && first_rsp < 0) first_rsp = rel_cnt;
        if (bus.instr_valid && first_valid < 0) begin
          first_valid = rel_cnt;
          checkOutput("first_instr_latency", 64'(first_valid), 64'(first_rsp + 1));
        end
`ifdef YSYX_220066_IFU_PERF_EN
        checkOutput("perf_fetched", perf_fetched, 64'(hs_since_reset));
        checkOutput("perf_stall", perf_stall, 64'(stall_since_reset));
`endif
        if (!bus.instr_valid && !bus.halt) stall_since_reset++;

        if (bus.imem_req_valid) begin
          checkOutput("req_while_halt", 64'(bus.halt), 64'd0);
          checkOutput("req_while_redirect", 64'(bus.redirect), 64'd0);
          checkOutput("req_addr_aligned", 64'(bus.imem_req_addr[1:0]), 64'd0);
          checkOutput("req_after_fault", 64'(fault_epoch == mon_epoch), 64'd0);
          if (prev_stall) checkOutput("req_addr_stable", bus.imem_req_addr, prev_addr);
        end
        prev_stall = bus.imem_req_valid && !bus.imem_req_ready;
        prev_addr  = bus.imem_req_addr;

        if (bus.instr_valid && bus.instr_ready) begin
          if (rd_idx >= exp_q.size()) begin
            tests++;
            fails++;
            $display("[TB] FAIL instr_beyond_stream: got pc 0x%0h, expected no handshake", bus.instr_pc);
          end else begin
            exp = exp_q[rd_idx];
            rd_idx++;
            checkOutput("instr", 64'(bus.instr), 64'(exp.instr));
            checkOutput("instr_pc", bus.instr_pc, exp.pc);
            checkOutput("instr_err", 64'(bus.instr_err), 64'(exp.err));
            if (exp.err) fault_epoch = mon_epoch;
          end
          hs_since_reset++;
          total_hs++;
        end
      end
      if (done && !final_done) begin
        final_done = 1'b1;
        checkOutput("handshakes_seen", 64'(total_hs >= 200), 64'd1);
      end
    end
  end
endmodule
